// File: rtl/jesd204_rx_dyncfg_pkg.sv
// Shared definitions for the JESD204 RX runtime configuration sequencer:
// FSM encodings, fixed link-core settings and the multiframe octet limit.
package jesd204_rx_dyncfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HOLD,
    ST_APPLY,
    ST_RELEASE
  } dyncfg_state_e;

  localparam int unsigned MAX_OCTETS_PER_MFRAME = 1024;

  localparam logic       CHAR_REPLACEMENT_DISABLE  = 1'b0;
  localparam logic [7:0] FRAME_ALIGN_ERR_THRESHOLD = 8'd4;
  localparam logic [7:0] LMFC_OFFSET               = 8'd1;
  localparam logic       SYSREF_DISABLE            = 1'b0;
  localparam logic       BUFFER_EARLY_RELEASE      = 1'b0;
  localparam logic [7:0] BUFFER_DELAY              = 8'd0;

endpackage

// File: rtl/jesd204_rx_dyncfg_check.sv
// Combinational validation of a latched F/K/lane-disable request; also derives
// the octets-per-multiframe and beats-per-multiframe values to be applied.
module jesd204_rx_dyncfg_check
  import jesd204_rx_dyncfg_pkg::*;
#(
  parameter int NUM_LANES           = 1,
  parameter int DATA_PATH_WIDTH     = 4,
  parameter int TPL_DATA_PATH_WIDTH = 4
) (
  input  logic [7:0]           octets_per_frame_i,
  input  logic [8:0]           frames_per_mframe_i,
  input  logic [NUM_LANES-1:0] lanes_disable_i,
  output logic                 valid_o,
  output logic [9:0]           octets_per_mframe_o,
  output logic [7:0]           beats_per_mframe_o
);

  localparam int TPL_SHIFT = $clog2(TPL_DATA_PATH_WIDTH);

  logic [16:0] octets_total;

  assign octets_total = 17'(octets_per_frame_i) * 17'(frames_per_mframe_i);

  // Both widths are powers of two, so divisibility reduces to a low-bit mask.
  always_comb begin
    valid_o = (octets_per_frame_i != 8'd0)
           && (frames_per_mframe_i != 9'd0)
           && (octets_total <= 17'(MAX_OCTETS_PER_MFRAME))
           && ((octets_total & 17'(DATA_PATH_WIDTH - 1)) == 17'd0)
           && ((octets_total & 17'(TPL_DATA_PATH_WIDTH - 1)) == 17'd0)
           && !(&lanes_disable_i);
  end

  assign octets_per_mframe_o = 10'(octets_total - 17'd1);
  assign beats_per_mframe_o  = 8'((octets_total >> TPL_SHIFT) - 17'd1);

endmodule

// File: rtl/jesd204_rx_dynamic_config.sv
// Runtime L/F/K/SCR configuration sequencer: validates a request, holds the RX link
// in reset, applies all config outputs on one edge, then releases the link.
// Optional macro JESD204_RX_DYNCFG_ERR_CNT_EN adds a saturating rejected-request counter.
module jesd204_rx_dynamic_config
  import jesd204_rx_dyncfg_pkg::*;
#(
  parameter int NUM_LANES                     = 1,
  parameter int NUM_LINKS                     = 1,
  parameter int LINK_MODE                     = 1,
  parameter int DATA_PATH_WIDTH               = (LINK_MODE == 2) ? 8 : 4,
  parameter int TPL_DATA_PATH_WIDTH           = (LINK_MODE == 2) ? 8 : 4,
  parameter int DEFAULT_OCTETS_PER_FRAME      = 1,
  parameter int DEFAULT_FRAMES_PER_MULTIFRAME = 32,
  parameter int DEFAULT_SCR                   = 1,
  parameter int RESET_HOLD_CYCLES             = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
  output logic [7:0]           err_count,
`endif
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_octets_per_frame,
  input  logic [8:0]           req_frames_per_mframe,
  input  logic [NUM_LANES-1:0] req_lanes_disable,
  input  logic [NUM_LINKS-1:0] req_links_disable,
  input  logic                 req_scr,
  input  logic                 req_sysref_oneshot,
  output logic                 resp_valid,
  output logic                 resp_error,
  output logic                 link_reset,
  output logic [NUM_LANES-1:0] cfg_lanes_disable,
  output logic [NUM_LINKS-1:0] cfg_links_disable,
  output logic [9:0]           cfg_octets_per_multiframe,
  output logic [7:0]           cfg_octets_per_frame,
  output logic                 cfg_disable_scrambler,
  output logic                 cfg_disable_char_replacement,
  output logic [7:0]           cfg_frame_align_err_threshold,
  output logic [9:0]           device_cfg_octets_per_multiframe,
  output logic [7:0]           device_cfg_octets_per_frame,
  output logic [7:0]           device_cfg_beats_per_multiframe,
  output logic [7:0]           device_cfg_lmfc_offset,
  output logic                 device_cfg_sysref_oneshot,
  output logic                 device_cfg_sysref_disable,
  output logic                 device_cfg_buffer_early_release,
  output logic [7:0]           device_cfg_buffer_delay
);

  localparam int         DEF_P     = DEFAULT_OCTETS_PER_FRAME * DEFAULT_FRAMES_PER_MULTIFRAME;
  localparam logic [7:0] DEF_F     = 8'(DEFAULT_OCTETS_PER_FRAME);
  localparam logic [8:0] DEF_K     = 9'(DEFAULT_FRAMES_PER_MULTIFRAME);
  localparam logic [9:0] DEF_OPM   = 10'(DEF_P - 1);
  localparam logic [7:0] DEF_OPF   = 8'(DEFAULT_OCTETS_PER_FRAME - 1);
  localparam logic [7:0] DEF_BEATS = 8'(DEF_P / TPL_DATA_PATH_WIDTH - 1);
  localparam logic       DEF_SCR   = (DEFAULT_SCR != 0);
  localparam int         CNT_W     = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);

  dyncfg_state_e        state_q;
  logic [CNT_W-1:0]     hold_cnt_q;
  logic                 startup_q;
  logic [7:0]           req_f_q;
  logic [8:0]           req_k_q;
  logic [NUM_LANES-1:0] req_lanes_q;
  logic [NUM_LINKS-1:0] req_links_q;
  logic                 req_scr_q;
  logic                 req_oneshot_q;
  logic [NUM_LANES-1:0] lanes_dis_q;
  logic [NUM_LINKS-1:0] links_dis_q;
  logic [9:0]           opm_q;
  logic [7:0]           opf_q;
  logic [7:0]           beats_q;
  logic                 scr_dis_q;
  logic                 oneshot_q;
  logic                 link_reset_q;
  logic                 resp_valid_q;
  logic                 resp_error_q;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
  logic [7:0]           err_cnt_q;
`endif

  logic       chk_valid;
  logic [9:0] chk_opm;
  logic [7:0] chk_beats;

  jesd204_rx_dyncfg_check #(
    .NUM_LANES          (NUM_LANES),
    .DATA_PATH_WIDTH    (DATA_PATH_WIDTH),
    .TPL_DATA_PATH_WIDTH(TPL_DATA_PATH_WIDTH)
  ) u_check (
    .octets_per_frame_i (req_f_q),
    .frames_per_mframe_i(req_k_q),
    .lanes_disable_i    (req_lanes_q),
    .valid_o            (chk_valid),
    .octets_per_mframe_o(chk_opm),
    .beats_per_mframe_o (chk_beats)
  );

  // The startup pass replays the reset-value request latches through APPLY,
  // so defaults reach the link core through the same path as a real request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= HOLD_LOAD;
      startup_q     <= 1'b1;
      req_f_q       <= DEF_F;
      req_k_q       <= DEF_K;
      req_lanes_q   <= '0;
      req_links_q   <= '0;
      req_scr_q     <= DEF_SCR;
      req_oneshot_q <= 1'b0;
      lanes_dis_q   <= '0;
      links_dis_q   <= '0;
      opm_q         <= DEF_OPM;
      opf_q         <= DEF_OPF;
      beats_q       <= DEF_BEATS;
      scr_dis_q     <= !DEF_SCR;
      oneshot_q     <= 1'b0;
      link_reset_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
      err_cnt_q     <= 8'd0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_f_q       <= req_octets_per_frame;
            req_k_q       <= req_frames_per_mframe;
            req_lanes_q   <= req_lanes_disable;
            req_links_q   <= req_links_disable;
            req_scr_q     <= req_scr;
            req_oneshot_q <= req_sysref_oneshot;
            state_q       <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_valid) begin
            hold_cnt_q   <= HOLD_LOAD;
            link_reset_q <= 1'b1;
            state_q      <= ST_HOLD;
          end else begin
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            state_q      <= ST_IDLE;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) state_q <= ST_APPLY;
          else                  hold_cnt_q <= hold_cnt_q - 1'b1;
        end
        ST_APPLY: begin
          lanes_dis_q  <= req_lanes_q;
          links_dis_q  <= req_links_q;
          opm_q        <= chk_opm;
          opf_q        <= req_f_q - 8'd1;
          beats_q      <= chk_beats;
          scr_dis_q    <= !req_scr_q;
          oneshot_q    <= req_oneshot_q;
          link_reset_q <= 1'b0;
          resp_valid_q <= !startup_q;
          startup_q    <= 1'b0;
          state_q      <= ST_RELEASE;
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign link_reset = link_reset_q;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
  assign err_count  = err_cnt_q;
`endif

  assign cfg_lanes_disable                = lanes_dis_q;
  assign cfg_links_disable                = links_dis_q;
  assign cfg_octets_per_multiframe        = opm_q;
  assign cfg_octets_per_frame             = opf_q;
  assign cfg_disable_scrambler            = scr_dis_q;
  assign cfg_disable_char_replacement     = CHAR_REPLACEMENT_DISABLE;
  assign cfg_frame_align_err_threshold    = FRAME_ALIGN_ERR_THRESHOLD;
  assign device_cfg_octets_per_multiframe = opm_q;
  assign device_cfg_octets_per_frame      = opf_q;
  assign device_cfg_beats_per_multiframe  = beats_q;
  assign device_cfg_lmfc_offset           = LMFC_OFFSET;
  assign device_cfg_sysref_oneshot        = oneshot_q;
  assign device_cfg_sysref_disable        = SYSREF_DISABLE;
  assign device_cfg_buffer_early_release  = BUFFER_EARLY_RELEASE;
  assign device_cfg_buffer_delay          = BUFFER_DELAY;

endmodule

// File: tb/tb_jesd204_rx_dynamic_config.sv
// Self-checking bench for jesd204_rx_dynamic_config (default parameters).
// Build with JESD204_RX_DYNCFG_ERR_CNT_EN defined to also check err_count.
module tb_jesd204_rx_dynamic_config;

  localparam int HOLD = 16;
  localparam int DPW  = 4;
  localparam int TPL  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_octets_per_frame;
  logic [8:0] req_frames_per_mframe;
  logic [0:0] req_lanes_disable;
  logic [0:0] req_links_disable;
  logic       req_scr;
  logic       req_sysref_oneshot;
  logic       resp_valid;
  logic       resp_error;
  logic       link_reset;
  logic [0:0] cfg_lanes_disable;
  logic [0:0] cfg_links_disable;
  logic [9:0] cfg_octets_per_multiframe;
  logic [7:0] cfg_octets_per_frame;
  logic       cfg_disable_scrambler;
  logic       cfg_disable_char_replacement;
  logic [7:0] cfg_frame_align_err_threshold;
  logic [9:0] device_cfg_octets_per_multiframe;
  logic [7:0] device_cfg_octets_per_frame;
  logic [7:0] device_cfg_beats_per_multiframe;
  logic [7:0] device_cfg_lmfc_offset;
  logic       device_cfg_sysref_oneshot;
  logic       device_cfg_sysref_disable;
  logic       device_cfg_buffer_early_release;
  logic [7:0] device_cfg_buffer_delay;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  jesd204_rx_dynamic_config dut (
    .clk                             (clk),
    .reset                           (reset),
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
    .err_count                       (err_count),
`endif
    .req_valid                       (req_valid),
    .req_ready                       (req_ready),
    .req_octets_per_frame            (req_octets_per_frame),
    .req_frames_per_mframe           (req_frames_per_mframe),
    .req_lanes_disable               (req_lanes_disable),
    .req_links_disable               (req_links_disable),
    .req_scr                         (req_scr),
    .req_sysref_oneshot              (req_sysref_oneshot),
    .resp_valid                      (resp_valid),
    .resp_error                      (resp_error),
    .link_reset                      (link_reset),
    .cfg_lanes_disable               (cfg_lanes_disable),
    .cfg_links_disable               (cfg_links_disable),
    .cfg_octets_per_multiframe       (cfg_octets_per_multiframe),
    .cfg_octets_per_frame            (cfg_octets_per_frame),
    .cfg_disable_scrambler           (cfg_disable_scrambler),
    .cfg_disable_char_replacement    (cfg_disable_char_replacement),
    .cfg_frame_align_err_threshold   (cfg_frame_align_err_threshold),
    .device_cfg_octets_per_multiframe(device_cfg_octets_per_multiframe),
    .device_cfg_octets_per_frame     (device_cfg_octets_per_frame),
    .device_cfg_beats_per_multiframe (device_cfg_beats_per_multiframe),
    .device_cfg_lmfc_offset          (device_cfg_lmfc_offset),
    .device_cfg_sysref_oneshot       (device_cfg_sysref_oneshot),
    .device_cfg_sysref_disable       (device_cfg_sysref_disable),
    .device_cfg_buffer_early_release (device_cfg_buffer_early_release),
    .device_cfg_buffer_delay         (device_cfg_buffer_delay)
  );

  // Applied configuration as seen on the outputs: {lanes, links, opm, opf, beats, scr_dis, oneshot}
  typedef struct packed {
    logic       lanes;
    logic       links;
    logic [9:0] opm;
    logic [7:0] opf;
    logic [7:0] beats;
    logic       scr_dis;
    logic       oneshot;
  } cfg_t;

  typedef struct {
    logic err;
    cfg_t cfg;
  } exp_t;

  localparam cfg_t DEFAULT_CFG = '{lanes: 1'b0, links: 1'b0, opm: 10'd31, opf: 8'd0,
                                   beats: 8'd7, scr_dis: 1'b0, oneshot: 1'b0};

  exp_t exp_q[$];
  cfg_t cur_cfg;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_err_cnt = 0;

  function automatic cfg_t dut_cfg();
    cfg_t c;
    c.lanes   = cfg_lanes_disable[0];
    c.links   = cfg_links_disable[0];
    c.opm     = cfg_octets_per_multiframe;
    c.opf     = cfg_octets_per_frame;
    c.beats   = device_cfg_beats_per_multiframe;
    c.scr_dis = cfg_disable_scrambler;
    c.oneshot = device_cfg_sysref_oneshot;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, wait for acceptance and push the reference outcome.
  task automatic send_req(input int f, input int k, input logic lanes, input logic links,
                          input logic scr, input logic oneshot);
    exp_t e;
    int   p;
    int   w;
    req_octets_per_frame  = 8'(f);
    req_frames_per_mframe = 9'(k);
    req_lanes_disable     = lanes;
    req_links_disable     = links;
    req_scr               = scr;
    req_sysref_oneshot    = oneshot;
    req_valid             = 1'b1;
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL accept_ready: req_ready=%b required 1", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    p = f * k;
    e.err = !(f >= 1 && k >= 1 && p <= 1024 && (p % DPW) == 0 && (p % TPL) == 0 && lanes != 1'b1);
    if (e.err) e.cfg = cur_cfg;
    else e.cfg = '{lanes: lanes, links: links, opm: 10'(p - 1), opf: 8'(f - 1),
                   beats: 8'(p / TPL - 1), scr_dis: !scr, oneshot: oneshot};
    exp_q.push_back(e);
  endtask

  // Scoreboard sink: wait for resp_valid, check latency, atomicity and payload.
  task automatic collect_resp();
    exp_t e;
    int   lat;
    int   cnt;
    bit   got;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_empty: queue size=0 required >0");
      return;
    end
    n_pass++;
    e   = exp_q.pop_front();
    lat = e.err ? 1 : HOLD + 2;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 100) begin
      tick();
      cnt++;
      if (cnt == 1) begin
        n_checks++;
        if (link_reset !== !e.err) $display("FAIL link_reset_c2: got=%b required %b", link_reset, !e.err);
        else n_pass++;
      end
      if (resp_valid === 1'b1) got = 1'b1;
      else begin
        n_checks++;
        if (dut_cfg() !== cur_cfg) $display("FAIL cfg_atomic: cycle=%0d got=%h required %h", cnt, dut_cfg(), cur_cfg);
        else n_pass++;
      end
    end
    n_checks++;
    if (!got) begin
      $display("FAIL resp_timeout: no resp_valid within %0d cycles", cnt);
      return;
    end
    if (cnt !== lat) $display("FAIL resp_latency: got=%0d required %0d", cnt, lat);
    else n_pass++;
    n_checks++;
    if (resp_error !== e.err) $display("FAIL resp_error: got=%b required %b", resp_error, e.err);
    else n_pass++;
    n_checks++;
    if (dut_cfg() !== e.cfg) $display("FAIL cfg_value: got=%h required %h", dut_cfg(), e.cfg);
    else n_pass++;
    n_checks++;
    if ({device_cfg_octets_per_multiframe, device_cfg_octets_per_frame} !== {e.cfg.opm, e.cfg.opf})
      $display("FAIL device_cfg_mirror: got=%h/%h required %h/%h", device_cfg_octets_per_multiframe,
               device_cfg_octets_per_frame, e.cfg.opm, e.cfg.opf);
    else n_pass++;
    n_checks++;
    if (link_reset !== 1'b0) $display("FAIL link_reset_resp: got=%b required 0", link_reset);
    else n_pass++;
    if (e.err && exp_err_cnt < 255) exp_err_cnt++;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'(exp_err_cnt)) $display("FAIL err_count: got=%0d required %0d", err_count, exp_err_cnt);
    else n_pass++;
`endif
    cur_cfg = e.cfg;
    tick();
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL resp_pulse: resp_valid=%b required 0", resp_valid);
    else n_pass++;
  endtask

  // Checks applied while reset is asserted and through the startup hold.
  task automatic check_startup();
    int  cnt;
    bit  saw_resp;
    n_checks++;
    if ({link_reset, resp_valid, resp_error, req_ready} !== 4'b1000)
      $display("FAIL rst_ctrl: {lr,rv,re,rdy}=%b required 1000", {link_reset, resp_valid, resp_error, req_ready});
    else n_pass++;
    n_checks++;
    if (dut_cfg() !== DEFAULT_CFG) $display("FAIL rst_cfg: got=%h required %h", dut_cfg(), DEFAULT_CFG);
    else n_pass++;
`ifdef JESD204_RX_DYNCFG_ERR_CNT_EN
    n_checks++;
    if (err_count !== 8'd0) $display("FAIL rst_err_count: got=%0d required 0", err_count);
    else n_pass++;
`endif
    @(negedge clk);
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      tick();
      if (resp_valid === 1'b1) saw_resp = 1'b1;
      n_checks++;
      if (link_reset !== 1'b1) $display("FAIL startup_hold: cycle=%0d link_reset=%b required 1", i, link_reset);
      else n_pass++;
    end
    cnt = 0;
    while (link_reset === 1'b1 && cnt < 10) begin
      tick();
      if (resp_valid === 1'b1) saw_resp = 1'b1;
      cnt++;
    end
    n_checks++;
    if (link_reset !== 1'b0) $display("FAIL startup_release: link_reset=%b required 0", link_reset);
    else n_pass++;
    n_checks++;
    if (dut_cfg() !== DEFAULT_CFG) $display("FAIL startup_cfg: got=%h required %h", dut_cfg(), DEFAULT_CFG);
    else n_pass++;
    tick();
    if (resp_valid === 1'b1) saw_resp = 1'b1;
    n_checks++;
    if (saw_resp !== 1'b0) $display("FAIL startup_resp: saw resp_valid=%b required 0", saw_resp);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL startup_idle: req_ready=%b required 1", req_ready);
    else n_pass++;
    n_checks++;
    if ({cfg_disable_char_replacement, cfg_frame_align_err_threshold, device_cfg_lmfc_offset,
         device_cfg_sysref_disable, device_cfg_buffer_early_release, device_cfg_buffer_delay}
        !== {1'b0, 8'd4, 8'd1, 1'b0, 1'b0, 8'd0})
      $display("FAIL const_outputs: thr=%0d lmfc=%0d dly=%0d", cfg_frame_align_err_threshold,
               device_cfg_lmfc_offset, device_cfg_buffer_delay);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    exp_q.delete();
    cur_cfg     = DEFAULT_CFG;
    exp_err_cnt = 0;
    check_startup();
  endtask

  task automatic test_valid();
    send_req(2, 32, 1'b0, 1'b0, 1'b1, 1'b0);   // opm 63, opf 1, beats 15
    collect_resp();
    send_req(4, 256, 1'b0, 1'b1, 1'b0, 1'b1);  // exactly the 1024-octet limit
    collect_resp();
    send_req(1, 4, 1'b0, 1'b0, 1'b1, 1'b0);    // smallest legal multiframe
    collect_resp();
  endtask

  task automatic test_invalid();
    send_req(4, 257, 1'b0, 1'b0, 1'b1, 1'b0);  // P=1028 over limit
    collect_resp();
    send_req(3, 10, 1'b0, 1'b0, 1'b1, 1'b0);   // P=30 not a multiple of 4
    collect_resp();
    send_req(0, 32, 1'b0, 1'b0, 1'b1, 1'b0);
    collect_resp();
    send_req(2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    collect_resp();
    send_req(2, 32, 1'b1, 1'b0, 1'b1, 1'b0);   // every lane disabled
    collect_resp();
  endtask

  task automatic test_reset_mid();
    send_req(8, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) tick();
    n_checks++;
    if (link_reset !== 1'b1) $display("FAIL mid_hold: link_reset=%b required 1", link_reset);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    cur_cfg     = DEFAULT_CFG;
    exp_err_cnt = 0;
    check_startup();
  endtask

  task automatic test_back_to_back();
    int cnt;
    send_req(2, 32, 1'b0, 1'b0, 1'b1, 1'b0);
    req_octets_per_frame  = 8'd8;
    req_frames_per_mframe = 9'd32;
    req_lanes_disable     = 1'b0;
    req_links_disable     = 1'b1;
    req_scr               = 1'b0;
    req_sysref_oneshot    = 1'b1;
    req_valid             = 1'b1;
    cnt = 0;
    while (resp_valid !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      n_checks++;
      if (req_ready !== 1'b0) $display("FAIL b2b_busy_ready: cycle=%0d req_ready=%b required 0", cnt, req_ready);
      else n_pass++;
    end
    n_checks++;
    if (cnt !== HOLD + 2) $display("FAIL b2b_first_latency: got=%0d required %0d", cnt, HOLD + 2);
    else n_pass++;
    n_checks++;
    if ({resp_error, cfg_octets_per_multiframe} !== {1'b0, 10'd63})
      $display("FAIL b2b_first_cfg: err=%b opm=%0d required 0/63", resp_error, cfg_octets_per_multiframe);
    else n_pass++;
    exp_q.delete();
    cur_cfg = '{lanes: 1'b0, links: 1'b0, opm: 10'd63, opf: 8'd1, beats: 8'd15, scr_dis: 1'b0, oneshot: 1'b0};
    tick();
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL b2b_idle_ready: req_ready=%b required 1", req_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL b2b_accepted: req_ready=%b required 0", req_ready);
    else n_pass++;
    exp_q.push_back('{err: 1'b0, cfg: '{lanes: 1'b0, links: 1'b1, opm: 10'd255, opf: 8'd7,
                                        beats: 8'd63, scr_dis: 1'b1, oneshot: 1'b1}});
    collect_resp();
  endtask

  initial begin
    reset                 = 1'b1;
    req_valid             = 1'b0;
    req_octets_per_frame  = 8'd0;
    req_frames_per_mframe = 9'd0;
    req_lanes_disable     = 1'b0;
    req_links_disable     = 1'b0;
    req_scr               = 1'b0;
    req_sysref_oneshot    = 1'b0;
    cur_cfg               = DEFAULT_CFG;
    test_reset();
    test_valid();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
